// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the 16-channel PWM peripheral.
// Imported by the interface, the timebase and the top module.
package pwm_pkg;

    localparam int CLK_DIV_DEF = 13;
    localparam int PWM_WIDTH = 8;
    localparam int NUM_CH = 16;
    localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;

    // Full-scale duty is a true 100% level with no dip at count 0xFF.
    function automatic logic pwm_level(
        input logic [PWM_WIDTH-1:0] count,
        input logic [PWM_WIDTH-1:0] duty
    );
        return (duty == DUTY_FULL) || (count < duty);
    endfunction

endpackage

// File: rtl/pwm_if.sv
// Register-side inputs and pin-side outputs of the PWM peripheral.
// master drives the register file values; slave is the peripheral.
interface pwm_if;
    import pwm_pkg::*;

    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [PWM_WIDTH-1:0] pwm_duty_cycle;
    logic [NUM_CH-1:0] out;
    logic pwm_sync;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  pwm_sync
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output pwm_sync
    );

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: clock prescaler feeding an 8-bit period counter.
// period_start marks the first system clock of each 256-step period.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_WIDTH-1:0] count,
    output logic                 tick,
    output logic                 period_start
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] prescaler;

    assign tick = (prescaler == DIV_LAST);
    assign period_start = (count == '0) && (prescaler == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= 8'd0;
            count <= '0;
        end else begin
            prescaler <= tick ? 8'd0 : prescaler + 8'd1;
            if (tick) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output block: shadowed duty, shared compare, per-pin mux.
// All channels run from one timebase so their edges stay aligned.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input logic clk,
    input logic rst_n,
    pwm_if.slave bus
);

    logic [PWM_WIDTH-1:0] count;
    logic                 period_start;
    logic                 unused_tick;
    logic [PWM_WIDTH-1:0] shadow;
    logic [PWM_WIDTH-1:0] duty_eff;
    logic                 level;
    logic [NUM_CH-1:0]    en_out;
    logic [NUM_CH-1:0]    en_pwm;
    logic [NUM_CH-1:0]    drive;

    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk(clk),
        .rst_n(rst_n),
        .count(count),
        .tick(unused_tick),
        .period_start(period_start)
    );

    // The first step of a period already uses the duty being loaded.
    assign duty_eff = period_start ? bus.pwm_duty_cycle : shadow;
    assign level = pwm_level(count, duty_eff);

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
    assign drive = en_out & (~en_pwm | {NUM_CH{level}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            bus.out <= '0;
            bus.pwm_sync <= 1'b0;
        end else begin
            if (period_start) begin
                shadow <= bus.pwm_duty_cycle;
            end
            bus.out <= drive;
            bus.pwm_sync <= period_start;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: cycle model derived from elapsed clocks since
// reset, checked every cycle, plus literal pulse-width and sync checks.
module tb_pwm_peripheral;
    import pwm_pkg::*;

    localparam int DIV = 13;
    localparam int P = 256 * DIV;

    logic clk;
    logic rst_n;
    pwm_if bus ();

    pwm_peripheral #(.CLK_DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ncmp = 0;
    int nerr = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: clocks elapsed since release define prescaler and count.
    int unsigned n = 0;
    int unsigned ph;
    int unsigned stp;
    logic [7:0] duty_m = 8'h00;
    logic [15:0] exp_out = 16'h0000;
    logic exp_sync = 1'b0;
    logic lvl;
    logic [15:0] eo;
    logic [15:0] ep;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            duty_m = 8'h00;
            exp_out = 16'h0000;
            exp_sync = 1'b0;
        end else begin
            ph = n % P;
            stp = ph / DIV;
            if (ph == 0) duty_m = bus.pwm_duty_cycle;
            lvl = (duty_m == 8'hFF) || (stp < 32'(duty_m));
            eo = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
            ep = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
            for (int i = 0; i < 16; i++) begin
                if (!eo[i]) exp_out[i] = 1'b0;
                else if (!ep[i]) exp_out[i] = 1'b1;
                else exp_out[i] = lvl;
            end
            exp_sync = (ph == 0);
            n++;
        end
    end

    always @(negedge clk) begin
        check("out", 32'(bus.out), 32'(exp_out));
        check("pwm_sync", 32'(bus.pwm_sync), 32'(exp_sync));
    end

    task automatic set_regs(logic [15:0] e_o, logic [15:0] e_p,
                            logic [7:0] d);
        bus.en_reg_out_7_0 = e_o[7:0];
        bus.en_reg_out_15_8 = e_o[15:8];
        bus.en_reg_pwm_7_0 = e_p[7:0];
        bus.en_reg_pwm_15_8 = e_p[15:8];
        bus.pwm_duty_cycle = d;
    endtask

    task automatic wait_sync();
        int k;
        for (k = 0; k < 2 * P; k++) begin
            @(negedge clk);
            if (bus.pwm_sync) break;
        end
        check("wait_sync_timeout", 32'(k < 2 * P), 32'd1);
    endtask

    // Counts from the current negedge over len samples.
    task automatic measure(int len, output int hi, output int lo,
                           output int syncs);
        hi = 0;
        lo = 0;
        syncs = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.out[0]) hi++;
            else lo++;
            if (bus.pwm_sync) syncs++;
        end
    endtask

    int hi, lo, sy;

    initial begin
        rst_n = 1'b0;
        set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
        repeat (5) @(negedge clk);
        check("reset_out", 32'(bus.out), 32'h0);
        check("reset_sync", 32'(bus.pwm_sync), 32'h0);

        @(posedge clk);
        #3;
        rst_n = 1'b1;
        set_regs(16'h00FF, 16'h0000, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("static_first", 32'(bus.out), 32'h00FF);
        check("release_sync", 32'(bus.pwm_sync), 32'h1);
        repeat (20) @(negedge clk);
        check("static_held", 32'(bus.out), 32'h00FF);
        set_regs(16'hFF00, 16'h0000, 8'h00);
        @(negedge clk);
        check("enable_swap", 32'(bus.out), 32'hFF00);

        set_regs(16'h0001, 16'h0001, 8'h80);
        wait_sync();
        measure(P, hi, lo, sy);
        check("duty80_high", 32'(hi), 32'd1664);
        check("duty80_low", 32'(lo), 32'd1664);
        check("duty80_syncs", 32'(sy), 32'd1);
        @(negedge clk);
        check("sync_period", 32'(bus.pwm_sync), 32'h1);

        bus.pwm_duty_cycle = 8'h00;
        wait_sync();
        measure(3 * P, hi, lo, sy);
        check("duty00_high", 32'(hi), 32'd0);
        check("duty00_syncs", 32'(sy), 32'd3);

        bus.pwm_duty_cycle = 8'hFF;
        wait_sync();
        measure(3 * P, hi, lo, sy);
        check("dutyFF_high", 32'(hi), 32'd9984);

        bus.pwm_duty_cycle = 8'h40;
        wait_sync();
        hi = 0;
        for (int i = 0; i < P; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 32'h20 * DIV) bus.pwm_duty_cycle = 8'hC0;
            if (bus.out[0]) hi++;
        end
        check("midchange_high", 32'(hi), 32'd832);
        @(negedge clk);
        check("midchange_sync", 32'(bus.pwm_sync), 32'h1);
        measure(P, hi, lo, sy);
        check("next_high", 32'(hi), 32'd2496);

        bus.pwm_duty_cycle = 8'h80;
        wait_sync();
        repeat (32'h90 * DIV) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.pwm_duty_cycle = 8'h10;
        #1;
        check("async_rst_out", 32'(bus.out), 32'h0);
        check("async_rst_sync", 32'(bus.pwm_sync), 32'h0);
        repeat (3) @(negedge clk);
        check("rst_hold_out", 32'(bus.out), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rerelease_sync", 32'(bus.pwm_sync), 32'h1);
        check("rerelease_out", 32'(bus.out), 32'h1);
        measure(P, hi, lo, sy);
        check("reload_high", 32'(hi), 32'd208);
        check("reload_syncs", 32'(sy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter CLK_DIV, default 13: system clocks per PWM counter step; legal range 1..255.
REQ-002 clk  input  1  system clock (10 MHz nominal); all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; one clock domain only.
REQ-004 en_reg_out_7_0  input  8  output enables for out[7:0], from SPI register 0x00.
REQ-005 en_reg_out_15_8  input  8  output enables for out[15:8], from SPI register 0x01.
REQ-006 en_reg_pwm_7_0  input  8  PWM mode enables for out[7:0], from SPI register 0x02.
REQ-007 en_reg_pwm_15_8  input  8  PWM mode enables for out[15:8], from SPI register 0x03.
REQ-008 pwm_duty_cycle  input  8  shared duty value, from SPI register 0x04.
REQ-009 out  output  16  registered drive pins.
REQ-010 pwm_sync  output  1  one-clock pulse marking the start of each PWM period.

Function
REQ-011 Register inputs are treated as quasi-static clk-domain signals; no extra synchronisation inside this block.
REQ-012 Prescaler: counts 0..CLK_DIV-1, wraps to 0; tick asserted when prescaler == CLK_DIV-1.
REQ-013 PWM counter: 8-bit, increments on tick only, wraps 255 -> 0 (period = 256*CLK_DIV clocks; 3328 at default, ~3.0 kHz).
REQ-014 Period start: the cycle with pwm counter == 0 and prescaler == 0; includes the first cycle after reset release.
REQ-015 Shadow duty register loads pwm_duty_cycle on the period-start cycle only.
REQ-016 Duty changes mid-period are ignored until the next period start; no glitch or truncated pulse.
REQ-017 Raw PWM level = 1 if shadow == 0xFF, else (pwm counter < shadow), 8-bit unsigned compare.
REQ-018 Duty 0x00: raw level constantly 0. Duty 0xFF: constantly 1 (true 100%, no one-step dip).
REQ-019 Per bit i: en_out[i]=0 -> out[i]=0; en_out[i]=1 and en_pwm[i]=0 -> out[i]=1; both 1 -> out[i]=raw PWM level.
REQ-020 Enable changes are not period-aligned; out reflects new enables one clock after the change.
REQ-021 out is registered: one clock latency from counter/shadow/enable state to pin.
REQ-022 pwm_sync is registered and asserted for exactly one clock, aligned with the first out update of each period.
REQ-023 All 16 channels share one timebase; PWM edges of all active channels are simultaneous.

Reset
REQ-024 While rst_n=0: prescaler=0, pwm counter=0, shadow duty=0x00, out=16'h0000, pwm_sync=0.
REQ-025 Assertion mid-period clears all state immediately (asynchronous); no completion of the current period.
REQ-026 After release, the first clock edge is a period start (REQ-014) and loads the current pwm_duty_cycle.

Structure
REQ-027 Shared package pwm_pkg holds CLK_DIV default, PWM_WIDTH=8, NUM_CH=16, and DUTY_FULL=8'hFF.
REQ-028 One sub-module, pwm_timebase: prescaler, pwm counter, tick and period-start outputs; the top module holds shadow duty, compare, and output mux.
REQ-029 The top module instantiates pwm_timebase once; no per-channel counters.

Verification
REQ-030 Reset: hold rst_n=0 with all inputs 0xFF -> out=0x0000 and pwm_sync=0 throughout.
REQ-031 Static drive: en_out=0x00FF, en_pwm=0x0000 -> out=0x00FF one clock later and held.
REQ-032 Duty 0x80, en_out=en_pwm=0x0001, CLK_DIV=13 -> out[0] high 1664 clocks, low 1664 clocks; pwm_sync every 3328 clocks.
REQ-033 Duty 0x00 -> out[0] constantly 0; duty 0xFF -> out[0] constantly 1 across 3 periods.
REQ-034 Duty 0x40 changed to 0xC0 at pwm counter 0x20 -> current period high ends at count 0x40; next period high lasts 0xC0 steps.
REQ-035 rst_n pulsed low at pwm counter 0x90 -> out=0x0000 during reset; next pwm_sync on the first clock after release; duty reloaded.
